grid_io_bank: RTL and testbench
===============================

# grid_io_bank

Multi-channel, parametrised I/O grid tile for the eFPGA perimeter. It replaces the single-pad I/O tile with NUM_SUBTILE independent pads. Each pad has configuration-chain-selectable direction, an optional output register and an optional input synchroniser. Configuration shifts in through the ccff chain shared with the rest of the fabric and is applied to the pads atomically at the end of a shift burst, so no partially shifted mode ever reaches the pads.

## Interface
- NUM_SUBTILE, 4, number of pad channels (1..32)
- SYNC_STAGES, 2, input synchroniser depth when sync mode is selected (1..4)
- CHAIN_LEN (local), 3*NUM_SUBTILE, configuration bits held by the tile

- prog_clk  input  1  single clock; drives the config chain and all pad-path registers
- prog_reset_n  input  1  reset, synchronous, active-low
- ccff_head  input  1  serial configuration data in
- ccff_en  input  1  shift enable; chain shifts one bit per cycle while high
- ccff_tail  output  1  serial configuration data out (= chain[CHAIN_LEN-1], registered)
- top_pin_outpad  input  NUM_SUBTILE  fabric-to-pad data, one bit per subtile
- top_pin_inpad  output  NUM_SUBTILE  pad-to-fabric data
- gfpga_pad_GPIO_in  input  NUM_SUBTILE  pad receive data
- gfpga_pad_GPIO_out  output  NUM_SUBTILE  pad drive data
- gfpga_pad_GPIO_oe  output  NUM_SUBTILE  pad output enable, 1 = drive
- cfg_done  output  1  active configuration loaded from an exact-length burst
- cfg_err  output  1  last burst length was not equal to CHAIN_LEN

## Operation
- Per-subtile configuration bits, subtile k at chain[3k+2:3k]:
  - bit0 = dir (0 input, 1 output)
  - bit1 = reg_out
  - bit2 = in_sync
- Shift: while ccff_en=1, each cycle chain <= {chain[CHAIN_LEN-2:0], ccff_head}. The first bit shifted in lands at chain[CHAIN_LEN-1], so the host sends the configuration vector MSB first.
- Shift length counter: increments on each shift cycle and saturates at CHAIN_LEN+1.
- Apply: on the first cycle with ccff_en=0 following a cycle with ccff_en=1:
  - active_cfg <= chain
  - cfg_done <= (count==CHAIN_LEN)
  - cfg_err <= (count!=CHAIN_LEN)
  - count <= 0
- Safe state while ccff_en=1: all gfpga_pad_GPIO_oe=0, top_pin_inpad=0, and cfg_done drops to 0 on the first shift cycle. active_cfg is unchanged during the shift.
- Output path, subtile k with dir=1:
  - oe=1
  - gfpga_pad_GPIO_out = top_pin_outpad[k] when reg_out=0, otherwise out_q[k], a flop of top_pin_outpad[k]
- Output path with dir=0: oe=0 and gfpga_pad_GPIO_out=0.
- Input path with dir=0:
  - in_sync=0: top_pin_inpad[k] = gfpga_pad_GPIO_in[k] (combinational)
  - in_sync=1: input passes through the SYNC_STAGES flop chain
- Input path with dir=1: top_pin_inpad[k]=0. Synchroniser flops keep sampling regardless of mode.
- Reset (prog_reset_n=0 at a prog_clk edge) clears to 0: chain, active_cfg, count, out_q, sync flops, cfg_done, cfg_err. Resulting outputs: ccff_tail=0, oe=0, GPIO_out=0, inpad=0, cfg_done=0, cfg_err=0.
- Reset during a shift burst aborts the burst. No apply occurs until a new burst completes.

## Timing
- ccff_tail presents a bit CHAIN_LEN cycles after it entered at ccff_head.
- Apply edge: active_cfg, cfg_done and cfg_err update at the first rising edge with ccff_en=0 after a burst. The new pad mode is visible in the following cycle.
- Output latency: reg_out=0 is 0 cycles; reg_out=1 is 1 cycle.
- Input latency: in_sync=0 is 0 cycles; in_sync=1 is SYNC_STAGES cycles.
- Reg-out mode switch: out_q samples every cycle, so switching reg_out on shows a value already current, with no stale data beyond 1 cycle.
- Back-to-back bursts separated by a single ccff_en=0 cycle are legal. Each burst applies independently.
- ccff_en held high longer than CHAIN_LEN+1 cycles: count saturates, and cfg_err=1 at apply.

## Test plan
- Reset: hold prog_reset_n=0 for 2 cycles with random inputs -> all outputs 0. With pad_in=1 and outpad=1 after release and no configuration, inpad=0, oe=0, GPIO_out=0.
- NUM_SUBTILE=4 exact burst: shift 12 bits MSB first for subtile3=011, subtile2=100, subtile1=001, subtile0=000 -> cfg_done=1, cfg_err=0 one cycle after ccff_en falls. oe=4'b1010, and subtile1 out follows outpad with 0 latency.
- Registered output and synchronised input: subtile3 with reg_out=1 -> out lags outpad by exactly 1 cycle. Subtile2 with in_sync=1 and a pad_in pulse -> inpad pulse delayed by SYNC_STAGES=2 cycles.
- Short burst of 11 bits -> cfg_err=1, cfg_done=0, and active_cfg takes the shifted chain contents. Long burst of 20 bits -> cfg_err=1.
- Safe state and pass-through: during any burst oe=0 and inpad=0. Shifting a 12-bit pattern followed by 12 zeros -> the pattern emerges at ccff_tail starting exactly 12 cycles after entry.
- Reset at bit 6 of a burst -> no apply and outputs 0. A following full 12-bit burst -> cfg_done=1.

Source files
------------

// File: rtl/grid_io_bank_if.sv
// Pad and configuration-chain signals of one grid_io_bank tile.
// The master side is the fabric/host; the slave side is the tile itself.
interface grid_io_bank_if #(
    parameter int NUM_SUBTILE = 4
);
    logic                   ccff_head;
    logic                   ccff_en;
    logic                   ccff_tail;
    logic [NUM_SUBTILE-1:0] top_pin_outpad;
    logic [NUM_SUBTILE-1:0] top_pin_inpad;
    logic [NUM_SUBTILE-1:0] gfpga_pad_GPIO_in;
    logic [NUM_SUBTILE-1:0] gfpga_pad_GPIO_out;
    logic [NUM_SUBTILE-1:0] gfpga_pad_GPIO_oe;
    logic                   cfg_done;
    logic                   cfg_err;

    modport master (
        output ccff_head, ccff_en, top_pin_outpad, gfpga_pad_GPIO_in,
        input  ccff_tail, top_pin_inpad, gfpga_pad_GPIO_out, gfpga_pad_GPIO_oe,
        input  cfg_done, cfg_err
    );

    modport slave (
        input  ccff_head, ccff_en, top_pin_outpad, gfpga_pad_GPIO_in,
        output ccff_tail, top_pin_inpad, gfpga_pad_GPIO_out, gfpga_pad_GPIO_oe,
        output cfg_done, cfg_err
    );
endinterface

// File: rtl/grid_io_bank.sv
// Multi-pad eFPGA perimeter I/O tile: serial config chain applied atomically at
// the end of each shift burst, per-pad direction, output register and input sync.
module grid_io_bank #(
    parameter int NUM_SUBTILE = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          prog_clk,
    input  logic          prog_reset_n,
    grid_io_bank_if.slave bus
);
    localparam int CHAIN_LEN = 3 * NUM_SUBTILE;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_EXACT = CNT_W'(CHAIN_LEN);

    logic [CHAIN_LEN-1:0]   chain_reg;
    logic [CHAIN_LEN-1:0]   active_cfg_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   en_d_reg;
    logic                   cfg_done_reg;
    logic                   cfg_err_reg;
    logic                   cfg_valid_reg;
    logic [NUM_SUBTILE-1:0] out_q_reg;

    logic [NUM_SUBTILE-1:0] oe_w;
    logic [NUM_SUBTILE-1:0] out_w;
    logic [NUM_SUBTILE-1:0] inpad_w;

    // An apply happens on the first idle cycle after a shift cycle; clearing
    // en_d_reg on reset is what makes a reset abort an in-flight burst.
    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            chain_reg      <= '0;
            active_cfg_reg <= '0;
            count_reg      <= '0;
            en_d_reg       <= 1'b0;
            cfg_done_reg   <= 1'b0;
            cfg_err_reg    <= 1'b0;
            cfg_valid_reg  <= 1'b0;
            out_q_reg      <= '0;
        end else begin
            en_d_reg  <= bus.ccff_en;
            out_q_reg <= bus.top_pin_outpad;
            if (bus.ccff_en) begin
                chain_reg    <= {chain_reg[CHAIN_LEN-2:0], bus.ccff_head};
                cfg_done_reg <= 1'b0;
                if (count_reg != CNT_MAX) begin
                    count_reg <= count_reg + 1'b1;
                end
            end else if (en_d_reg) begin
                active_cfg_reg <= chain_reg;
                cfg_done_reg   <= (count_reg == CNT_EXACT);
                cfg_err_reg    <= (count_reg != CNT_EXACT);
                cfg_valid_reg  <= 1'b1;
                count_reg      <= '0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SUBTILE; gi++) begin : g_pad
            logic                   dir;
            logic                   reg_out;
            logic                   in_sync;
            logic [SYNC_STAGES-1:0] sync_reg;

            assign dir     = active_cfg_reg[3*gi];
            assign reg_out = active_cfg_reg[3*gi+1];
            assign in_sync = active_cfg_reg[3*gi+2];

            // Synchroniser runs in every mode so enabling it never exposes stale data.
            always_ff @(posedge prog_clk) begin
                if (!prog_reset_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg[0] <= bus.gfpga_pad_GPIO_in[gi];
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        sync_reg[s] <= sync_reg[s-1];
                    end
                end
            end

            assign oe_w[gi]    = dir & ~bus.ccff_en;
            assign out_w[gi]   = dir & (reg_out ? out_q_reg[gi] : bus.top_pin_outpad[gi]);
            // An unconfigured tile reports no input even though all-zero decodes as input.
            assign inpad_w[gi] = ~dir & ~bus.ccff_en & cfg_valid_reg &
                                 (in_sync ? sync_reg[SYNC_STAGES-1] : bus.gfpga_pad_GPIO_in[gi]);
        end
    endgenerate

    assign bus.gfpga_pad_GPIO_oe  = oe_w;
    assign bus.gfpga_pad_GPIO_out = out_w;
    assign bus.top_pin_inpad      = inpad_w;
    assign bus.ccff_tail          = chain_reg[CHAIN_LEN-1];
    assign bus.cfg_done           = cfg_done_reg;
    assign bus.cfg_err            = cfg_err_reg;
endmodule

// File: tb/tb_grid_io_bank.sv
// Directed bench for grid_io_bank (4 subtiles, 2 sync stages); inputs change
// and outputs are sampled 1 ns after the rising edge.
module tb_grid_io_bank;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    grid_io_bank_if #(.NUM_SUBTILE(4)) bus ();

    grid_io_bank #(
        .NUM_SUBTILE(4),
        .SYNC_STAGES(2)
    ) dut (
        .prog_clk    (clk),
        .prog_reset_n(rst_n),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Shifts n bits of v, MSB first; returns 1 ns after the last shift edge with ccff_en low.
    task automatic shift_burst(input logic [31:0] v, input int n);
        bus.ccff_en = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            bus.ccff_head = v[i];
            step();
        end
        bus.ccff_en   = 1'b0;
        bus.ccff_head = 1'b0;
        $display("burst: %0d bits value=%h", n, v);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.ccff_head         = 1'($urandom);
            bus.ccff_en           = 1'($urandom);
            bus.top_pin_outpad    = 4'($urandom);
            bus.gfpga_pad_GPIO_in = 4'($urandom);
            step();
        end
        checks++;
        if ({bus.ccff_tail, bus.gfpga_pad_GPIO_oe, bus.gfpga_pad_GPIO_out, bus.top_pin_inpad,
             bus.cfg_done, bus.cfg_err} !== 15'b0) begin
            errors++;
            $display("FAIL reset_outputs: got tail=%b oe=%b out=%b inpad=%b done=%b err=%b, want all 0",
                     bus.ccff_tail, bus.gfpga_pad_GPIO_oe, bus.gfpga_pad_GPIO_out,
                     bus.top_pin_inpad, bus.cfg_done, bus.cfg_err);
        end
        bus.ccff_en           = 1'b0;
        bus.ccff_head         = 1'b0;
        bus.gfpga_pad_GPIO_in = 4'hF;
        bus.top_pin_outpad    = 4'hF;
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({bus.gfpga_pad_GPIO_oe, bus.gfpga_pad_GPIO_out, bus.top_pin_inpad} !== 12'b0) begin
            errors++;
            $display("FAIL unconfigured_pads: got oe=%b out=%b inpad=%b, want 0000 0000 0000",
                     bus.gfpga_pad_GPIO_oe, bus.gfpga_pad_GPIO_out, bus.top_pin_inpad);
        end
        $display("reset: released, unconfigured pads checked");
    endtask

    task automatic test_exact_burst;
        bus.top_pin_outpad    = 4'h0;
        bus.gfpga_pad_GPIO_in = 4'h0;
        shift_burst(32'h708, 12);
        step();
        checks++;
        if ({bus.cfg_done, bus.cfg_err} !== 2'b10) begin
            errors++;
            $display("FAIL exact_done_err: got done=%b err=%b, want done=1 err=0",
                     bus.cfg_done, bus.cfg_err);
        end
        checks++;
        if (bus.gfpga_pad_GPIO_oe !== 4'b1010) begin
            errors++;
            $display("FAIL exact_oe: got %b, want 1010", bus.gfpga_pad_GPIO_oe);
        end
        bus.top_pin_outpad = 4'b0010;
        #1;
        checks++;
        if (bus.gfpga_pad_GPIO_out[1] !== 1'b1) begin
            errors++;
            $display("FAIL comb_out_high: got %b, want 1", bus.gfpga_pad_GPIO_out[1]);
        end
        bus.top_pin_outpad = 4'b0000;
        #1;
        checks++;
        if (bus.gfpga_pad_GPIO_out[1] !== 1'b0) begin
            errors++;
            $display("FAIL comb_out_low: got %b, want 0", bus.gfpga_pad_GPIO_out[1]);
        end
        bus.gfpga_pad_GPIO_in = 4'b0001;
        #1;
        checks++;
        if (bus.top_pin_inpad[0] !== 1'b1) begin
            errors++;
            $display("FAIL comb_in: got %b, want 1", bus.top_pin_inpad[0]);
        end
        bus.gfpga_pad_GPIO_in = 4'b0000;
        step();
    endtask

    task automatic test_regout_sync;
        bus.top_pin_outpad = 4'b0000;
        step();
        bus.top_pin_outpad = 4'b1000;
        #1;
        checks++;
        if (bus.gfpga_pad_GPIO_out[3] !== 1'b0) begin
            errors++;
            $display("FAIL regout_lag0: got %b, want 0", bus.gfpga_pad_GPIO_out[3]);
        end
        step();
        checks++;
        if (bus.gfpga_pad_GPIO_out[3] !== 1'b1) begin
            errors++;
            $display("FAIL regout_rise: got %b, want 1", bus.gfpga_pad_GPIO_out[3]);
        end
        bus.top_pin_outpad = 4'b0000;
        #1;
        checks++;
        if (bus.gfpga_pad_GPIO_out[3] !== 1'b1) begin
            errors++;
            $display("FAIL regout_hold: got %b, want 1", bus.gfpga_pad_GPIO_out[3]);
        end
        step();
        checks++;
        if (bus.gfpga_pad_GPIO_out[3] !== 1'b0) begin
            errors++;
            $display("FAIL regout_fall: got %b, want 0", bus.gfpga_pad_GPIO_out[3]);
        end
        $display("regout: subtile3 one-cycle lag checked");

        bus.gfpga_pad_GPIO_in = 4'b0100;
        #1;
        checks++;
        if (bus.top_pin_inpad[2] !== 1'b0) begin
            errors++;
            $display("FAIL sync_cycle0: got %b, want 0", bus.top_pin_inpad[2]);
        end
        step();
        bus.gfpga_pad_GPIO_in = 4'b0000;
        checks++;
        if (bus.top_pin_inpad[2] !== 1'b0) begin
            errors++;
            $display("FAIL sync_cycle1: got %b, want 0", bus.top_pin_inpad[2]);
        end
        step();
        checks++;
        if (bus.top_pin_inpad[2] !== 1'b1) begin
            errors++;
            $display("FAIL sync_cycle2: got %b, want 1", bus.top_pin_inpad[2]);
        end
        step();
        checks++;
        if (bus.top_pin_inpad[2] !== 1'b0) begin
            errors++;
            $display("FAIL sync_cycle3: got %b, want 0", bus.top_pin_inpad[2]);
        end
        $display("sync: subtile2 pulse delayed two cycles checked");
    endtask

    task automatic test_bad_length;
        // chain holds 0x708 (bit0=0), so 11 more bits 0x249 leave 0x249.
        shift_burst(32'h249, 11);
        step();
        checks++;
        if ({bus.cfg_done, bus.cfg_err} !== 2'b01) begin
            errors++;
            $display("FAIL short_done_err: got done=%b err=%b, want done=0 err=1",
                     bus.cfg_done, bus.cfg_err);
        end
        checks++;
        if (bus.gfpga_pad_GPIO_oe !== 4'b1111) begin
            errors++;
            $display("FAIL short_applied_oe: got %b, want 1111", bus.gfpga_pad_GPIO_oe);
        end
        shift_burst(32'hFF001, 20);
        step();
        checks++;
        if ({bus.cfg_done, bus.cfg_err} !== 2'b01) begin
            errors++;
            $display("FAIL long_done_err: got done=%b err=%b, want done=0 err=1",
                     bus.cfg_done, bus.cfg_err);
        end
        checks++;
        if (bus.gfpga_pad_GPIO_oe !== 4'b0001) begin
            errors++;
            $display("FAIL long_applied_oe: got %b, want 0001", bus.gfpga_pad_GPIO_oe);
        end
    endtask

    task automatic test_safe_passthrough;
        logic [11:0] pattern;
        logic [23:0] stream;
        pattern = 12'hA5C;
        stream  = {pattern, 12'h000};
        bus.gfpga_pad_GPIO_in = 4'hF;
        #1;
        checks++;
        if (bus.top_pin_inpad !== 4'b1110) begin
            errors++;
            $display("FAIL pre_burst_inpad: got %b, want 1110", bus.top_pin_inpad);
        end
        bus.ccff_en = 1'b1;
        for (int j = 1; j <= 24; j++) begin
            bus.ccff_head = stream[24-j];
            step();
            checks++;
            if (bus.gfpga_pad_GPIO_oe !== 4'b0000 || bus.top_pin_inpad !== 4'b0000) begin
                errors++;
                $display("FAIL safe_state cycle %0d: got oe=%b inpad=%b, want 0000 0000",
                         j, bus.gfpga_pad_GPIO_oe, bus.top_pin_inpad);
            end
            if (j >= 12 && j <= 23) begin
                checks++;
                if (bus.ccff_tail !== pattern[23-j]) begin
                    errors++;
                    $display("FAIL tail cycle %0d: got %b, want %b", j, bus.ccff_tail, pattern[23-j]);
                end
            end
        end
        bus.ccff_en   = 1'b0;
        bus.ccff_head = 1'b0;
        step();
        $display("passthrough: pattern %h streamed through ccff_tail", pattern);
    endtask

    task automatic test_back_to_back;
        logic [11:0] second;
        second = 12'h249;
        shift_burst(32'h708, 12);
        step();
        checks++;
        if (bus.cfg_done !== 1'b1 || bus.gfpga_pad_GPIO_oe !== 4'b1010) begin
            errors++;
            $display("FAIL b2b_first: got done=%b oe=%b, want 1 1010", bus.cfg_done, bus.gfpga_pad_GPIO_oe);
        end
        bus.ccff_en = 1'b1;
        for (int i = 11; i >= 0; i--) begin
            bus.ccff_head = second[i];
            step();
            if (i == 11) begin
                checks++;
                if (bus.cfg_done !== 1'b0) begin
                    errors++;
                    $display("FAIL done_drop: got %b, want 0", bus.cfg_done);
                end
            end
        end
        bus.ccff_en   = 1'b0;
        bus.ccff_head = 1'b0;
        step();
        checks++;
        if ({bus.cfg_done, bus.cfg_err} !== 2'b10 || bus.gfpga_pad_GPIO_oe !== 4'b1111) begin
            errors++;
            $display("FAIL b2b_second: got done=%b err=%b oe=%b, want 1 0 1111",
                     bus.cfg_done, bus.cfg_err, bus.gfpga_pad_GPIO_oe);
        end
        $display("back_to_back: two bursts with one idle cycle applied");
    endtask

    task automatic test_reset_mid_burst;
        bus.gfpga_pad_GPIO_in = 4'hF;
        bus.ccff_en = 1'b1;
        for (int i = 11; i >= 6; i--) begin
            bus.ccff_head = i[0];
            step();
        end
        rst_n       = 1'b0;
        bus.ccff_en = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({bus.ccff_tail, bus.gfpga_pad_GPIO_oe, bus.gfpga_pad_GPIO_out, bus.top_pin_inpad,
             bus.cfg_done, bus.cfg_err} !== 15'b0) begin
            errors++;
            $display("FAIL abort_outputs: got tail=%b oe=%b out=%b inpad=%b done=%b err=%b, want all 0",
                     bus.ccff_tail, bus.gfpga_pad_GPIO_oe, bus.gfpga_pad_GPIO_out,
                     bus.top_pin_inpad, bus.cfg_done, bus.cfg_err);
        end
        shift_burst(32'h708, 12);
        step();
        checks++;
        if ({bus.cfg_done, bus.cfg_err} !== 2'b10 || bus.gfpga_pad_GPIO_oe !== 4'b1010) begin
            errors++;
            $display("FAIL after_abort: got done=%b err=%b oe=%b, want 1 0 1010",
                     bus.cfg_done, bus.cfg_err, bus.gfpga_pad_GPIO_oe);
        end
        $display("reset_mid_burst: aborted burst then full reload");
    endtask

    initial begin
        checks                = 0;
        errors                = 0;
        rst_n                 = 1'b0;
        bus.ccff_head         = 1'b0;
        bus.ccff_en           = 1'b0;
        bus.top_pin_outpad    = 4'h0;
        bus.gfpga_pad_GPIO_in = 4'h0;
        test_reset();
        test_exact_burst();
        test_regout_sync();
        test_bad_length();
        test_safe_passthrough();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
